sprite_blitter: RTL and testbench

- Initiator side of the sprite/text ROM coordinate interface.
- On Start, walks every pixel of one SPRITE_W x SPRITE_H bitmap, drives PixelX/PixelY to a combinational sprite ROM, and samples the 6-bit colour it returns.
- Writes each opaque, on-screen pixel into the frame buffer at (OriginX+x, OriginY+y) through a valid/ready write port.
- Sits between the scene controller (which issues draw commands) and the frame-buffer write arbiter.

---
 rtl/sprite_blitter_pkg.sv | 21 ++
 rtl/sprite_scan_counter.sv | 52 +++++
 rtl/sprite_blitter.sv | 125 ++++++++++++
 tb/tb_sprite_blitter.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_blitter_pkg.sv
// Shared types and constants for the sprite blitter: FSM states, colour width,
// transparent colour and frame-buffer geometry defaults.
package sprite_blitter_pkg;

   localparam int unsigned ColorW      = 6;
   localparam int unsigned CoordW      = 10;
   localparam int unsigned PixW        = 6;
   localparam logic [ColorW-1:0] Transparent = 6'h00;

   localparam int unsigned FbWDefault  = 640;
   localparam int unsigned FbHDefault  = 480;
   localparam int unsigned AddrW       = $clog2(FbWDefault * FbHDefault);

   typedef enum logic [1:0] {
      StIdle,
      StScan,
      StDrain,
      StFinish
   } state_e;

endpackage

// File: rtl/sprite_scan_counter.sv
// Raster x/y counter over a Width x Height bitmap with clear, enable, wrap and
// last-pixel flag.
module sprite_scan_counter
   import sprite_blitter_pkg::*;
#(
   parameter int unsigned Width  = 42,
   parameter int unsigned Height = 38
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            clr_i,
   input  logic            en_i,
   output logic [PixW-1:0] x_o,
   output logic [PixW-1:0] y_o,
   output logic            last_o
);

   logic [PixW-1:0] x_d, x_q, y_d, y_q;
   logic            last_x;

   assign last_x = (x_q == PixW'(Width - 1));
   assign last_o = last_x && (y_q == PixW'(Height - 1));
   assign x_o    = x_q;
   assign y_o    = y_q;

   always_comb begin
      x_d = x_q;
      y_d = y_q;
      if (clr_i) begin
         x_d = '0;
         y_d = '0;
      end else if (en_i) begin
         if (last_x) begin
            x_d = '0;
            y_d = last_o ? '0 : y_q + 1'b1;
         end else begin
            x_d = x_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         x_q <= '0;
         y_q <= '0;
      end else begin
         x_q <= x_d;
         y_q <= y_d;
      end
   end

endmodule

// File: rtl/sprite_blitter.sv
// Sprite blitter: scans a sprite ROM and writes opaque, on-screen pixels into the
// frame buffer through a single-register valid/ready write stage.
module sprite_blitter
   import sprite_blitter_pkg::*;
#(
   parameter int unsigned       SPRITE_W    = 42,
   parameter int unsigned       SPRITE_H    = 38,
   parameter int unsigned       FB_W        = FbWDefault,
   parameter int unsigned       FB_H        = FbHDefault,
   parameter logic [ColorW-1:0] TRANSPARENT = Transparent
) (
   input  logic              Clk,
   input  logic              Reset_n,
   input  logic              Start,
   input  logic [CoordW-1:0] OriginX,
   input  logic [CoordW-1:0] OriginY,
   output logic              Busy,
   output logic              Done,
   output logic [PixW-1:0]   PixelX,
   output logic [PixW-1:0]   PixelY,
   input  logic [ColorW-1:0] Data,
   output logic [AddrW-1:0]  FbAddr,
   output logic [ColorW-1:0] FbData,
   output logic              FbWe,
   input  logic              FbReady
);

   state_e state_d, state_q;

   logic [CoordW-1:0] origin_x_d, origin_x_q, origin_y_d, origin_y_q;
   logic [AddrW-1:0]  fb_addr_d, fb_addr_q;
   logic [ColorW-1:0] fb_data_d, fb_data_q;
   logic              fb_we_d, fb_we_q;

   logic              accept, stall, scan_en, clr, last;
   logic [PixW-1:0]   pix_x, pix_y;
   logic [10:0]       x_abs, y_abs;
   logic [21:0]       addr_full;
   logic              visible;

   sprite_scan_counter #(
      .Width  (SPRITE_W),
      .Height (SPRITE_H)
   ) u_scan_counter (
      .clk_i  (Clk),
      .rst_ni (Reset_n),
      .clr_i  (clr),
      .en_i   (scan_en),
      .x_o    (pix_x),
      .y_o    (pix_y),
      .last_o (last)
   );

   assign accept  = fb_we_q && FbReady;
   assign stall   = fb_we_q && !FbReady;
   assign scan_en = (state_q == StScan) && !stall;
   assign clr     = (state_q == StIdle) && Start;

   // 11-bit sums so clipping sees the true position past the 10-bit origin range.
   always_comb begin
      x_abs     = 11'(origin_x_q) + 11'(pix_x);
      y_abs     = 11'(origin_y_q) + 11'(pix_y);
      addr_full = 22'(y_abs) * 22'(FB_W) + 22'(x_abs);
      visible   = (Data != TRANSPARENT) && (32'(x_abs) < FB_W) && (32'(y_abs) < FB_H);
   end

   always_comb begin
      origin_x_d = origin_x_q;
      origin_y_d = origin_y_q;
      fb_we_d    = fb_we_q;
      fb_addr_d  = fb_addr_q;
      fb_data_d  = fb_data_q;
      if (clr) begin
         origin_x_d = OriginX;
         origin_y_d = OriginY;
      end
      if (accept) fb_we_d = 1'b0;
      if (scan_en) begin
         fb_we_d   = visible;
         fb_addr_d = addr_full[AddrW-1:0];
         fb_data_d = Data;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:   if (Start) state_d = StScan;
         StScan:   if (scan_en && last) state_d = StDrain;
         StDrain:  if (!fb_we_q || FbReady) state_d = StFinish;
         StFinish: state_d = StIdle;
         default:  state_d = StIdle;
      endcase
   end

   always_comb begin
      Busy   = (state_q != StIdle);
      Done   = (state_q == StFinish);
      PixelX = pix_x;
      PixelY = pix_y;
      FbAddr = fb_addr_q;
      FbData = fb_data_q;
      FbWe   = fb_we_q;
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q    <= StIdle;
         origin_x_q <= '0;
         origin_y_q <= '0;
         fb_we_q    <= 1'b0;
         fb_addr_q  <= '0;
         fb_data_q  <= '0;
      end else begin
         state_q    <= state_d;
         origin_x_q <= origin_x_d;
         origin_y_q <= origin_y_d;
         fb_we_q    <= fb_we_d;
         fb_addr_q  <= fb_addr_d;
         fb_data_q  <= fb_data_d;
      end
   end

endmodule

// File: tb/tb_sprite_blitter.sv
// Scoreboard bench for sprite_blitter: a 2x2 instance and a default 42x38 instance
// driven with directed draws; a monitor per instance checks every accepted write.
module tb_sprite_blitter;

   typedef struct {
      logic [18:0] addr;
      logic [5:0]  data;
   } wr_t;

   logic       clk = 1'b0;
   logic       rst_n;
   int         checks = 0;
   int         errors = 0;

   logic       s_start, s_busy, s_done, s_we, s_ready;
   logic [9:0] s_ox, s_oy;
   logic [5:0] s_px, s_py, s_data, s_fbdata;
   logic [18:0] s_addr;

   logic       b_start, b_busy, b_done, b_we, b_ready;
   logic [9:0] b_ox, b_oy;
   logic [5:0] b_px, b_py, b_data, b_fbdata;
   logic [18:0] b_addr;
   logic       rom_op;

   wr_t        s_q[$];
   wr_t        b_q[$];
   int         s_acc = 0;
   int         b_acc = 0;
   logic [18:0] b_first;

   always #5 clk = ~clk;

   function automatic logic [5:0] rom_fn(input int x, input int y);
      return 6'(((x + 3 * y) % 63) + 1);
   endfunction

   always_comb s_data = rom_fn(int'(s_px), int'(s_py));
   always_comb b_data = rom_op ? rom_fn(int'(b_px), int'(b_py)) : 6'h00;

   sprite_blitter #(
      .SPRITE_W (2),
      .SPRITE_H (2)
   ) u_small (
      .Clk     (clk),
      .Reset_n (rst_n),
      .Start   (s_start),
      .OriginX (s_ox),
      .OriginY (s_oy),
      .Busy    (s_busy),
      .Done    (s_done),
      .PixelX  (s_px),
      .PixelY  (s_py),
      .Data    (s_data),
      .FbAddr  (s_addr),
      .FbData  (s_fbdata),
      .FbWe    (s_we),
      .FbReady (s_ready)
   );

   sprite_blitter u_big (
      .Clk     (clk),
      .Reset_n (rst_n),
      .Start   (b_start),
      .OriginX (b_ox),
      .OriginY (b_oy),
      .Busy    (b_busy),
      .Done    (b_done),
      .PixelX  (b_px),
      .PixelY  (b_py),
      .Data    (b_data),
      .FbAddr  (b_addr),
      .FbData  (b_fbdata),
      .FbWe    (b_we),
      .FbReady (b_ready)
   );

   task automatic check(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   always @(negedge clk) begin : mon_small
      wr_t e;
      if (s_we && s_ready) begin
         s_acc++;
         if (s_q.size() == 0) check("small_extra_write", 1, 0);
         else begin
            e = s_q.pop_front();
            check("small_addr", s_addr, e.addr);
            check("small_data", s_fbdata, e.data);
         end
      end
   end

   always @(negedge clk) begin : mon_big
      wr_t e;
      if (b_we && b_ready) begin
         b_acc++;
         if (b_acc == 1) b_first = b_addr;
         if (b_q.size() == 0) check("big_extra_write", 1, 0);
         else begin
            e = b_q.pop_front();
            check("big_addr", b_addr, e.addr);
            check("big_data", b_fbdata, e.data);
         end
      end
   end

   task automatic push_big(input int ox, input int oy);
      wr_t w;
      for (int y = 0; y < 38; y++) begin
         for (int x = 0; x < 42; x++) begin
            if (rom_op && (ox + x < 640) && (oy + y < 480)) begin
               w.addr = 19'((oy + y) * 640 + ox + x);
               w.data = rom_fn(x, y);
               b_q.push_back(w);
            end
         end
      end
   endtask

   task automatic push_small(input logic [18:0] a, input logic [5:0] d);
      wr_t w;
      w.addr = a;
      w.data = d;
      s_q.push_back(w);
   endtask

   task automatic run_small(input logic stall_en, input int exp_cyc);
      int   cyc = 0;
      logic stalled = 1'b0;
      logic [18:0] ha;
      logic [5:0]  hd, hx, hy;
      s_ox    = 10'd10;
      s_oy    = 10'd20;
      s_start = 1'b1;
      while (cyc < 100) begin
         @(posedge clk); #1;
         s_start = 1'b0;
         cyc++;
         if (stall_en && !stalled && s_we && s_acc == 2) begin
            stalled = 1'b1;
            s_ready = 1'b0;
            ha = s_addr; hd = s_fbdata; hx = s_px; hy = s_py;
            check("stall_third_addr", s_addr, 13450);
            repeat (5) begin
               @(posedge clk); #1;
               cyc++;
               check("stall_we_held", s_we, 1);
               check("stall_addr_held", s_addr, ha);
               check("stall_data_held", s_fbdata, hd);
               check("stall_pix_held", {s_px, s_py}, {hx, hy});
            end
            s_ready = 1'b1;
         end
         if (s_done) break;
      end
      check("small_done_cycle", cyc, exp_cyc);
      @(posedge clk); #1;
      check("small_busy_after_done", s_busy, 0);
      check("small_done_one_cycle", s_done, 0);
      check("small_queue_empty", s_q.size(), 0);
   endtask

   // Returns after Done plus a quiet window, or right after a mid-draw reset.
   task automatic run_big(input logic [9:0] ox, input logic [9:0] oy, input int restart_at,
                          input int reset_at, input int exp_writes);
      int cyc = 0;
      int dones = 0;
      int done_cyc = -1;
      b_acc   = 0;
      b_ox    = ox;
      b_oy    = oy;
      push_big(int'(ox), int'(oy));
      b_start = 1'b1;
      while (cyc < 5000 && dones == 0) begin
         @(posedge clk); #1;
         b_start = 1'b0;
         cyc++;
         if (cyc == restart_at) begin
            b_ox = 10'd0; b_oy = 10'd0; b_start = 1'b1;
         end
         if (cyc == reset_at) begin
            rst_n = 1'b0;
            #1;
            check("reset_fbwe_low", b_we, 0);
            check("reset_busy_low", b_busy, 0);
            check("reset_done_low", b_done, 0);
            b_q.delete();
            return;
         end
         if (b_done) begin
            dones++;
            done_cyc = cyc;
         end
      end
      check("big_done_cycle", done_cyc, 1598);
      repeat (10) begin
         @(posedge clk); #1;
         if (b_done) dones++;
         check("big_busy_after_done", b_busy, 0);
      end
      check("big_done_count", dones, 1);
      check("big_write_count", b_acc, exp_writes);
      check("big_queue_empty", b_q.size(), 0);
   endtask

   initial begin
      rst_n   = 1'b0;
      s_start = 1'b0; s_ox = '0; s_oy = '0; s_ready = 1'b1;
      b_start = 1'b0; b_ox = '0; b_oy = '0; b_ready = 1'b1;
      rom_op  = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("rst_busy", b_busy, 0);
      check("rst_done", b_done, 0);
      check("rst_fbwe", b_we, 0);
      check("rst_fbaddr", b_addr, 0);
      check("rst_fbdata", b_fbdata, 0);
      check("rst_pixel", {b_px, b_py}, 0);
      check("rst_small_fbwe", s_we, 0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      push_small(19'd12810, 6'd1);
      push_small(19'd12811, 6'd2);
      push_small(19'd13450, 6'd4);
      push_small(19'd13451, 6'd5);
      run_small(1'b0, 6);

      push_small(19'd12810, 6'd1);
      push_small(19'd12811, 6'd2);
      push_small(19'd13450, 6'd4);
      push_small(19'd13451, 6'd5);
      s_acc = 0;
      run_small(1'b1, 11);
      check("small_stall_write_count", s_acc, 4);

      rom_op = 1'b0;
      run_big(10'd0, 10'd0, 0, 0, 0);
      rom_op = 1'b1;

      run_big(10'd630, 10'd470, 0, 0, 100);
      check("clip_first_addr", b_first, 301430);

      run_big(10'd700, 10'd500, 0, 0, 0);

      run_big(10'd100, 10'd50, 50, 0, 1596);

      run_big(10'd0, 10'd0, 0, 100, 0);
      @(posedge clk); #1;
      check("reset_hold_fbwe", b_we, 0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      run_big(10'd5, 10'd7, 0, 0, 1596);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
